decode_stage: RTL
=================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter REG_W, default 32, meaning register and datapath width.
REQ-002 SHALL have parameter REG_COUNT, default 32, meaning number of architectural registers; REG_IDX_W = $clog2(REG_COUNT).
REQ-003 SHALL have ports: clk  input  1  single clock, rising edge; aresetn  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports: in_valid  input  1  fetch word valid; in_ready  output  1  stage can accept; in_instr  input  32  instruction; in_pc  input  REG_W  instruction address.
REQ-005 SHALL have ports: rd_reg_a  output  REG_IDX_W  rs1 index to register file; rd_reg_b  output  REG_IDX_W  rs2 index; rd_data_a  input  REG_W  rs1 value; rd_data_b  input  REG_W  rs2 value.
REQ-006 SHALL have ports: wr_en  input  1  writeback strobe (snooped); wr_reg  input  REG_IDX_W  writeback index; wr_data  input  REG_W  writeback value.
REQ-007 SHALL have ports: flush  input  1  squash held and incoming instruction.
REQ-008 SHALL have ports: out_valid  output  1; out_ready  input  1; out_pc  output  REG_W; out_op_a  output  REG_W; out_op_b  output  REG_W; out_imm  output  REG_W; out_rd  output  REG_IDX_W; out_opcode  output  7; out_funct3  output  3; out_funct7b5  output  1; out_illegal  output  1.

Function
REQ-009 SHALL drive rd_reg_a = in_instr[19:15] and rd_reg_b = in_instr[24:20] combinationally, independent of in_valid.
REQ-010 SHALL implement two states, EMPTY (out_valid=0) and FULL (out_valid=1); in_ready = (state==EMPTY) || out_ready.
REQ-011 SHALL capture all decoded fields into output registers on any rising edge where in_valid && in_ready && !flush; latency exactly 1 cycle; state becomes FULL.
REQ-012 SHALL go FULL->EMPTY when out_ready=1 and no new capture occurs; FULL->FULL with new data on simultaneous drain and capture.
REQ-013 SHALL hold every out_* register stable while out_valid && !out_ready.
REQ-014 SHALL, on flush=1, enter EMPTY on the next edge regardless of in_valid/out_ready; flush dominates capture.
REQ-015 SHALL force operand to 0 when source index is 0, regardless of rd_data or bypass.
REQ-016 SHALL sign-extend immediates per RV32I format: I (OP-IMM, LOAD, JALR), S (STORE), B (BRANCH, bit0=0), U (LUI, AUIPC, low 12 bits 0), J (JAL, bit0=0); out_imm=0 for R-type; sign bit is in_instr[31] extended to REG_W.
REQ-017 SHALL set out_illegal=1 for any opcode outside {0110011,0010011,0000011,0100011,1100011,0110111,0010111,1101111,1100111} or in_instr[1:0]!=2'b11; illegal words still propagate with out_valid=1.
REQ-018 SHALL set out_rd = in_instr[11:7] for writing formats and 0 for STORE, BRANCH and illegal instructions.

Reset
REQ-019 SHALL, while aresetn=0, asynchronously force state EMPTY, out_valid=0 and all out_* data registers to 0; in_ready=1 once reset releases.
REQ-020 SHALL discard a held instruction if reset asserts mid-stall; no capture on the edge reset deasserts unless in_valid is sampled after release.

Configuration
REQ-021 SHALL, with macro DECODE_BYPASS_EN defined, substitute wr_data for an operand when wr_en && wr_reg==source index && index!=0 in the capture cycle.
REQ-022 SHALL, without DECODE_BYPASS_EN, use rd_data_a/rd_data_b unmodified (register file assumed write-through); wr_* ports remain present but unused.

Structure
REQ-023 SHALL take opcode constants, format enum (R/I/S/B/U/J) and REG_W/REG_COUNT defaults from shared package brisc_pkg.
REQ-024 SHALL place immediate extraction in a combinational sub-module imm_gen (inputs instr, format; output REG_W immediate).

Verification
REQ-025 SHALL cover: ADDI x1,x0,5 (0x00500093), out_ready=1 -> next cycle out_valid=1, out_imm=5, out_rd=1, out_op_a=0, out_illegal=0.
REQ-026 SHALL cover: BEQ x0,x0,-4 (0xFE000EE3) -> out_imm=0xFFFFFFFC, out_rd=0, out_funct3=0.
REQ-027 SHALL cover: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 after first capture, out_* unchanged for 3 cycles, next word captured on cycle out_ready returns.
REQ-028 SHALL cover: flush=1 while FULL and in_valid=1 -> out_valid=0 next cycle, no word captured.
REQ-029 SHALL cover (DECODE_BYPASS_EN): ADD x3,x2,x2 (0x002101B3) with wr_en=1, wr_reg=2, wr_data=0xDEADBEEF, rd_data=0 -> out_op_a=out_op_b=0xDEADBEEF; wr_reg=0 -> operands 0.
REQ-030 SHALL cover: in_instr=0x00000000 -> out_illegal=1, out_rd=0, out_valid=1; aresetn pulsed low mid-stall -> out_valid=0 immediately.

Source files
------------

// File: rtl/brisc_pkg.sv
// Shared RV32I decode definitions: widths, opcodes, immediate formats and stage state.
package brisc_pkg;

  localparam int unsigned REG_W_DEF     = 32;
  localparam int unsigned REG_COUNT_DEF = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_e;

  typedef enum logic {ST_EMPTY, ST_FULL} state_e;

  // Control fields carried alongside the operands
  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate extraction, sign-extended to REG_W.
module imm_gen
  import brisc_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF
) (
  input  logic [31:0]      instr,
  input  fmt_e             fmt,
  output logic [REG_W-1:0] imm
);

  logic [31:0] imm32;
  logic        unused_opcode;

  assign unused_opcode = ^instr[6:0];

  always_comb begin
    imm32 = 32'd0;
    case (fmt)
      FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm32 = {instr[31:12], 12'd0};
      FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = 32'd0;
    endcase
  end

  assign imm = REG_W'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode pipeline stage with a one-entry output register and valid/ready handshake.
// Optional writeback bypass into the operands is enabled by defining DECODE_BYPASS_EN.
module decode_stage
  import brisc_pkg::*;
#(
  parameter int unsigned REG_W     = REG_W_DEF,
  parameter int unsigned REG_COUNT = REG_COUNT_DEF,
  localparam int unsigned REG_IDX_W = $clog2(REG_COUNT)
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_instr,
  input  logic [REG_W-1:0]     in_pc,
  output logic [REG_IDX_W-1:0] rd_reg_a,
  output logic [REG_IDX_W-1:0] rd_reg_b,
  input  logic [REG_W-1:0]     rd_data_a,
  input  logic [REG_W-1:0]     rd_data_b,
  input  logic                 wr_en,
  input  logic [REG_IDX_W-1:0] wr_reg,
  input  logic [REG_W-1:0]     wr_data,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_W-1:0]     out_pc,
  output logic [REG_W-1:0]     out_op_a,
  output logic [REG_W-1:0]     out_op_b,
  output logic [REG_W-1:0]     out_imm,
  output logic [REG_IDX_W-1:0] out_rd,
  output logic [6:0]           out_opcode,
  output logic [2:0]           out_funct3,
  output logic                 out_funct7b5,
  output logic                 out_illegal
);

  state_e                 state;
  ctrl_t                  ctrl_q;
  fmt_e                   fmt;
  logic                   legal;
  logic                   capture;
  logic [REG_W-1:0]       imm;
  logic [REG_W-1:0]       op_a;
  logic [REG_W-1:0]       op_b;
  logic [REG_IDX_W-1:0]   dest;

  assign rd_reg_a = REG_IDX_W'(in_instr[19:15]);
  assign rd_reg_b = REG_IDX_W'(in_instr[24:20]);

  // Opcode classification; unknown opcodes fall back to R format so their immediate is 0
  always_comb begin
    legal = 1'b1;
    fmt   = FMT_R;
    case (in_instr[6:0])
      OP_R:                     fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR: fmt = FMT_I;
      OP_STORE:                 fmt = FMT_S;
      OP_BRANCH:                fmt = FMT_B;
      OP_LUI, OP_AUIPC:         fmt = FMT_U;
      OP_JAL:                   fmt = FMT_J;
      default:                  legal = 1'b0;
    endcase
    if (in_instr[1:0] != 2'b11) legal = 1'b0;
  end

  imm_gen #(.REG_W(REG_W)) u_imm_gen (
    .instr (in_instr),
    .fmt   (fmt),
    .imm   (imm)
  );

  assign dest = (legal && fmt != FMT_S && fmt != FMT_B) ? REG_IDX_W'(in_instr[11:7])
                                                        : '0;

  // Operand selection; x0 always reads as zero
  always_comb begin
    op_a = rd_data_a;
    op_b = rd_data_b;
`ifdef DECODE_BYPASS_EN
    if (wr_en && wr_reg == rd_reg_a) op_a = wr_data;
    if (wr_en && wr_reg == rd_reg_b) op_b = wr_data;
`endif
    if (rd_reg_a == '0) op_a = '0;
    if (rd_reg_b == '0) op_b = '0;
  end

`ifndef DECODE_BYPASS_EN
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_reg, wr_data};
`endif

  assign in_ready  = (state == ST_EMPTY) || out_ready;
  assign capture   = in_valid && in_ready && !flush;
  assign out_valid = (state == ST_FULL);

  // Output register and EMPTY/FULL state; flush wins over capture
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= ST_EMPTY;
      out_pc   <= '0;
      out_op_a <= '0;
      out_op_b <= '0;
      out_imm  <= '0;
      out_rd   <= '0;
      ctrl_q   <= '0;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else if (capture) begin
      state           <= ST_FULL;
      out_pc          <= in_pc;
      out_op_a        <= op_a;
      out_op_b        <= op_b;
      out_imm         <= imm;
      out_rd          <= dest;
      ctrl_q.opcode   <= in_instr[6:0];
      ctrl_q.funct3   <= in_instr[14:12];
      ctrl_q.funct7b5 <= in_instr[30];
      ctrl_q.illegal  <= !legal;
    end else if (out_ready) begin
      state <= ST_EMPTY;
    end
  end

  assign out_opcode   = ctrl_q.opcode;
  assign out_funct3   = ctrl_q.funct3;
  assign out_funct7b5 = ctrl_q.funct7b5;
  assign out_illegal  = ctrl_q.illegal;

endmodule
